// File: rtl/regfile_sb.sv
// Register file with a per-register busy (scoreboard) bit, two forwarding read ports,
// one write port and one reservation port. The busy bit marks a destination awaiting its result.
module regfile_sb #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 2,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ok,
    output logic [ADDR_W:0]   busy_cnt,
    output logic              all_idle
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
    logic              all_idle_q;

    logic wr_is_r0, rsv_is_r0, rd1_is_r0, rd2_is_r0;
    logic wr_eff, rsv_set, cnt_inc, cnt_dec;

    // Register 0 is only special when hardwired; these flags fold ZERO_R0 in once.
    assign wr_is_r0  = ZERO_R0 && (wr_addr  == '0);
    assign rsv_is_r0 = ZERO_R0 && (rsv_addr == '0);
    assign rd1_is_r0 = ZERO_R0 && (rd_addr1 == '0);
    assign rd2_is_r0 = ZERO_R0 && (rd_addr2 == '0);

    // Writes are ignored during reset, so they neither forward nor update state then.
    assign wr_eff = we && !rst && !wr_is_r0;

    always_comb begin
        rd_data1 = mem_q[rd_addr1];
        rd_busy1 = busy_q[rd_addr1];
        if (rd1_is_r0) begin
            rd_data1 = '0;
            rd_busy1 = 1'b0;
        end else if (wr_eff && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
            rd_busy1 = 1'b0;
        end
    end

    always_comb begin
        rd_data2 = mem_q[rd_addr2];
        rd_busy2 = busy_q[rd_addr2];
        if (rd2_is_r0) begin
            rd_data2 = '0;
            rd_busy2 = 1'b0;
        end else if (wr_eff && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
            rd_busy2 = 1'b0;
        end
    end

    // A busy target is still grantable when a same-cycle write releases it.
    assign rsv_ok  = rsv_en && !rst &&
                     (!busy_q[rsv_addr] || (we && (wr_addr == rsv_addr)));
    assign rsv_set = rsv_ok && !rsv_is_r0;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        busy_d = busy_q;
        if (wr_eff)
            busy_d[wr_addr] = 1'b0;
        if (rsv_set)
            busy_d[rsv_addr] = 1'b1;
    end

    // Re-reserving a register that the same write releases leaves the count unchanged.
    assign cnt_inc = rsv_set && !busy_q[rsv_addr];
    assign cnt_dec = wr_eff && busy_q[wr_addr] && !(rsv_set && (rsv_addr == wr_addr));

    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (cnt_inc && !cnt_dec)
            busy_cnt_d = busy_cnt_q + 1'b1;
        else if (cnt_dec && !cnt_inc)
            busy_cnt_d = busy_cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            // NOTE: the storage array is reset here because no contents may survive reset.
            for (int i = 0; i < NREGS; i++)
                mem_q[i] <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
            all_idle_q <= 1'b1;
        end else begin
            if (wr_eff)
                mem_q[wr_addr] <= wr_data;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
            all_idle_q <= (busy_cnt_d == '0);
        end
    end

    assign busy_cnt = busy_cnt_q;
    assign all_idle = all_idle_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one instance with a normal r0 and one with r0 hardwired to zero,
// both driven by the same inputs.
module tb_regfile_sb;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] rd_addr1, rd_addr2, wr_addr, rsv_addr;
    logic [DATA_W-1:0] wr_data;
    logic              we, rsv_en;

    logic [DATA_W-1:0] rd_data1, rd_data2, z_rd_data1, z_rd_data2;
    logic              rd_busy1, rd_busy2, z_rd_busy1, z_rd_busy2;
    logic              rsv_ok, z_rsv_ok, all_idle, z_all_idle;
    logic [ADDR_W:0]   busy_cnt, z_busy_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(1'b0)) dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
        .busy_cnt(busy_cnt), .all_idle(all_idle)
    );

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(1'b1)) dut_z (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(z_rd_data1), .rd_data2(z_rd_data2),
        .rd_busy1(z_rd_busy1), .rd_busy2(z_rd_busy2),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(z_rsv_ok),
        .busy_cnt(z_busy_cnt), .all_idle(z_all_idle)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; rsv_en = 1'b0;
        wr_addr = '0; wr_data = '0; rsv_addr = '0;
    endtask

    initial begin
        rst = 1'b1;
        rd_addr1 = '0; rd_addr2 = '0;
        idle_inputs();
        tick();
        rst = 1'b0;
        #1;

        // Reset state of every register on both ports.
        for (int a = 0; a < 4; a++) begin
            rd_addr1 = 2'(a); rd_addr2 = 2'(3 - a);
            #1;
            check($sformatf("rst_data1_r%0d", a), rd_data1, 0);
            check($sformatf("rst_busy1_r%0d", a), rd_busy1, 0);
            check($sformatf("rst_data2_r%0d", 3 - a), rd_data2, 0);
            check($sformatf("rst_busy2_r%0d", 3 - a), rd_busy2, 0);
        end
        check("rst_cnt", busy_cnt, 0);
        check("rst_idle", all_idle, 1);

        // Reserve r2, then release it with a forwarded write.
        rsv_en = 1'b1; rsv_addr = 2'd2;
        #1 check("r2_rsv_ok", rsv_ok, 1);
        tick();
        idle_inputs();
        rd_addr1 = 2'd2; rd_addr2 = 2'd2;
        #1;
        check("r2_busy1", rd_busy1, 1);
        check("r2_busy2", rd_busy2, 1);
        check("r2_cnt1", busy_cnt, 1);
        check("r2_idle0", all_idle, 0);
        we = 1'b1; wr_addr = 2'd2; wr_data = 8'h5A;
        #1;
        check("r2_fwd_data1", rd_data1, 8'h5A);
        check("r2_fwd_busy1", rd_busy1, 0);
        check("r2_fwd_data2", rd_data2, 8'h5A);
        tick();
        idle_inputs();
        #1;
        check("r2_cnt0", busy_cnt, 0);
        check("r2_idle1", all_idle, 1);
        check("r2_stored", rd_data1, 8'h5A);

        // Busy r1: plain reservation rejected, reservation with same-cycle write granted.
        rsv_en = 1'b1; rsv_addr = 2'd1;
        tick();
        #1 check("r1_rej_ok", rsv_ok, 0);
        tick();
        check("r1_rej_cnt", busy_cnt, 1);
        we = 1'b1; wr_addr = 2'd1; wr_data = 8'h11;
        #1 check("r1_rewr_ok", rsv_ok, 1);
        tick();
        idle_inputs();
        rd_addr1 = 2'd1;
        #1;
        check("r1_rewr_data", rd_data1, 8'h11);
        check("r1_rewr_busy", rd_busy1, 1);
        check("r1_rewr_cnt", busy_cnt, 1);
        we = 1'b1; wr_addr = 2'd1; wr_data = 8'h12;
        tick();
        idle_inputs();
        #1 check("r1_rel_cnt", busy_cnt, 0);

        // Reservation of r3 and write of r2 in the same cycle act independently.
        rsv_en = 1'b1; rsv_addr = 2'd3;
        we = 1'b1; wr_addr = 2'd2; wr_data = 8'h77;
        tick();
        idle_inputs();
        rd_addr1 = 2'd2; rd_addr2 = 2'd3;
        #1;
        check("ind_data_r2", rd_data1, 8'h77);
        check("ind_busy_r2", rd_busy1, 0);
        check("ind_busy_r3", rd_busy2, 1);
        check("ind_cnt", busy_cnt, 1);
        we = 1'b1; wr_addr = 2'd3; wr_data = 8'h33;
        tick();
        idle_inputs();
        #1 check("ind_rel_cnt", busy_cnt, 0);

        // Fill the scoreboard, then drain it; the hardwired-r0 instance never counts r0.
        for (int a = 0; a < 4; a++) begin
            rsv_en = 1'b1; rsv_addr = 2'(a);
            tick();
            check($sformatf("fill_cnt_%0d", a), busy_cnt, a + 1);
        end
        idle_inputs();
        #1;
        check("fill_idle", all_idle, 0);
        check("fill_z_cnt", z_busy_cnt, 3);
        for (int a = 0; a < 4; a++) begin
            we = 1'b1; wr_addr = 2'(a); wr_data = 8'(8'hA0 + a);
            tick();
            check($sformatf("drain_cnt_%0d", a), busy_cnt, 3 - a);
        end
        idle_inputs();
        #1;
        check("drain_idle", all_idle, 1);
        check("drain_z_idle", z_all_idle, 1);

        // Register 0: hardwired instance discards everything, normal instance behaves normally.
        we = 1'b1; wr_addr = 2'd0; wr_data = 8'hFF;
        rsv_en = 1'b1; rsv_addr = 2'd0;
        rd_addr1 = 2'd0;
        #1;
        check("z_r0_fwd_data", z_rd_data1, 0);
        check("z_r0_fwd_busy", z_rd_busy1, 0);
        check("z_r0_rsv_ok", z_rsv_ok, 1);
        check("n_r0_fwd_data", rd_data1, 8'hFF);
        check("n_r0_rsv_ok", rsv_ok, 1);
        tick();
        idle_inputs();
        #1;
        check("z_r0_data", z_rd_data1, 0);
        check("z_r0_cnt", z_busy_cnt, 0);
        check("n_r0_data", rd_data1, 8'hFF);
        check("n_r0_busy", rd_busy1, 1);
        check("n_r0_cnt", busy_cnt, 1);
        we = 1'b1; wr_addr = 2'd0; wr_data = 8'h00;
        tick();
        idle_inputs();

        // Mid-operation reset discards reservations, writes and stored data.
        rsv_en = 1'b1; rsv_addr = 2'd3;
        tick();
        idle_inputs();
        we = 1'b1; wr_addr = 2'd1; wr_data = 8'h22;
        tick();
        rst = 1'b1;
        we = 1'b1; wr_addr = 2'd3; wr_data = 8'h33;
        rsv_en = 1'b1; rsv_addr = 2'd2;
        rd_addr1 = 2'd1; rd_addr2 = 2'd3;
        #1;
        check("mrst_cnt_before", busy_cnt, 1);
        check("mrst_rsv_ok", rsv_ok, 0);
        check("mrst_z_rsv_ok", z_rsv_ok, 0);
        check("mrst_hold_data", rd_data1, 8'h22);
        tick();
        rst = 1'b0;
        idle_inputs();
        for (int a = 0; a < 4; a++) begin
            rd_addr1 = 2'(a);
            #1;
            check($sformatf("mrst_data_r%0d", a), rd_data1, 0);
            check($sformatf("mrst_busy_r%0d", a), rd_busy1, 0);
            check($sformatf("mrst_z_data_r%0d", a), z_rd_data1, 0);
        end
        check("mrst_cnt", busy_cnt, 0);
        check("mrst_idle", all_idle, 1);
        check("mrst_z_cnt", z_busy_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 8, data width of each register.
REQ-002 Parameter ADDR_W, default 2, register address width; register count NREGS = 2**ADDR_W.
REQ-003 Parameter ZERO_R0, default 0; 1 = register 0 hardwired to zero.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 rd_addr1  in  ADDR_W  read port 1 address.
REQ-007 rd_addr2  in  ADDR_W  read port 2 address.
REQ-008 rd_data1  out  DATA_W  read port 1 data, combinational.
REQ-009 rd_data2  out  DATA_W  read port 2 data, combinational.
REQ-010 rd_busy1  out  1  read port 1 register has a pending write; data not yet valid.
REQ-011 rd_busy2  out  1  same for read port 2.
REQ-012 we  in  1  write enable.
REQ-013 wr_addr  in  ADDR_W  write address.
REQ-014 wr_data  in  DATA_W  write data.
REQ-015 rsv_en  in  1  request to reserve a destination register (mark busy).
REQ-016 rsv_addr  in  ADDR_W  register to reserve.
REQ-017 rsv_ok  out  1  reservation accepted this cycle, combinational.
REQ-018 busy_cnt  out  ADDR_W+1  registered count of busy registers.
REQ-019 all_idle  out  1  registered; 1 when busy_cnt == 0.

Function
REQ-020 Storage SHALL be NREGS x DATA_W registers plus one busy bit per register.
REQ-021 With we=1 and rst=0, mem[wr_addr] SHALL take wr_data at the clock edge; write is accepted whether or not the target is busy.
REQ-022 A write SHALL clear busy[wr_addr] at the same edge, unless an accepted reservation targets the same address in that cycle (REQ-026).
REQ-023 Read ports SHALL forward: if we=1 and wr_addr == rd_addrN, rd_dataN = wr_data and rd_busyN = 0; otherwise rd_dataN = mem[rd_addrN] and rd_busyN = busy[rd_addrN].
REQ-024 rsv_ok SHALL be rsv_en & ~rst & (~busy[rsv_addr] | (we & wr_addr == rsv_addr)); a busy target with no same-cycle release SHALL be rejected (rsv_ok=0, no state change).
REQ-025 An accepted reservation SHALL set busy[rsv_addr] at the clock edge.
REQ-026 Simultaneous accepted reservation and write to the same address: data written, busy stays 1, busy_cnt unchanged.
REQ-027 Reservation and write to different addresses in the same cycle SHALL both take effect independently.
REQ-028 busy_cnt SHALL track the number of set busy bits: +1 on accepted reservation only, -1 on release of a busy bit only, unchanged if both or neither; never exceeds NREGS, never underflows.
REQ-029 Write to a non-busy register SHALL leave busy_cnt unchanged.
REQ-030 ZERO_R0=1: reads of register 0 SHALL return 0 with busy 0, including no forwarding; writes to register 0 SHALL be discarded; rsv_ok SHALL be 1 for rsv_en to register 0 with no busy bit set and no count change.
REQ-031 ZERO_R0=0: register 0 SHALL behave as any other register.
REQ-032 Read ports SHALL be fully independent; both may address the same register.

Reset
REQ-033 While rst=1 at an edge: all registers <= 0, all busy bits <= 0, busy_cnt <= 0, all_idle <= 1; we and rsv_en in that cycle SHALL be ignored.
REQ-034 During rst=1, rsv_ok SHALL be 0; read ports continue to show current contents.
REQ-035 Reset asserted mid-operation SHALL discard all pending reservations; no write or busy state survives.

Verification
REQ-036 Reset, then read all registers -> all 0, rd_busy 0, busy_cnt 0, all_idle 1.
REQ-037 rsv_en r2; next cycle rd_addr1=2 -> rd_busy1=1, busy_cnt=1; we r2=0x5A same cycle as rd_addr1=2 -> rd_data1=0x5A, rd_busy1=0; next cycle busy_cnt=0.
REQ-038 r1 busy, rsv_en r1 without write -> rsv_ok=0, busy_cnt unchanged; rsv_en r1 with we r1=0x11 -> rsv_ok=1, r1=0x11, still busy, busy_cnt unchanged.
REQ-039 Reserve all 4 registers (ZERO_R0=0) over 4 cycles -> busy_cnt=4, all_idle=0; write all back -> busy_cnt=0, all_idle=1.
REQ-040 ZERO_R0=1: we r0=0xFF, rsv_en r0 -> rd_data=0, rd_busy=0, rsv_ok=1, busy_cnt=0.
REQ-041 Reserve r3, write r1=0x22, assert rst with we r3=0x33 -> after edge all registers 0, busy_cnt 0, rsv_ok 0 during rst.
